// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
//
// Time-multiplexed scan controller for a 4-digit common-select 7-segment
// display. An MCU writes segment bytes into a 4-entry digit register file
// through a four-phase level handshake. The block scans the four digits
// round-robin. Each digit slot has a SHOW phase, followed by a BLANK phase in
// which every digit is deselected so that the previous pattern does not ghost
// onto the next digit.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (show + blank), >= 2
//   BLANK_CYCLES  all-deselected cycles at the end of each slot,
//                 1 <= BLANK_CYCLES < SCAN_DIV
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   wr_strobe    in   MCU write request (asynchronous level, active-high)
//   wr_addr      in   digit index to write (stable while wr_strobe is high)
//   wr_data      in   segment byte {a,b,c,d,e,f,g,dp}, 1 = lit
//   enable       in   0 forces the display dark; scan and writes continue
//   wr_ack       out  handshake acknowledge, registered
//   digit_sel_n  out  active-low digit selects, one-cold or all-ones, registered
//   segments     out  segment lines of the selected digit, registered
// -----------------------------------------------------------------------------
module seg7_scan_controller #(
    parameter int SCAN_DIV     = 4096,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_strobe,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       enable,
    output logic       wr_ack,
    output logic [3:0] digit_sel_n,
    output logic [7:0] segments
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_HOLD = 1'b1
    } hs_state_t;

    typedef enum logic {
        SC_SHOW  = 1'b0,
        SC_BLANK = 1'b1
    } scan_state_t;

    // Active-low one-cold select pattern for a digit index.
    function automatic logic [3:0] digit_select(input logic [1:0] idx);
        logic [3:0] sel;
        case (idx)
            2'd0:    sel = 4'b1110;
            2'd1:    sel = 4'b1101;
            2'd2:    sel = 4'b1011;
            2'd3:    sel = 4'b0111;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    logic              strobe_s1_r;
    logic              strobe_s2_r;
    hs_state_t         hs_state_r;
    hs_state_t         hs_next_s;
    logic              mem_we_s;
    logic              wr_ack_r;
    logic [7:0]        digit_mem_r [4];

    scan_state_t       scan_state_r;
    scan_state_t       scan_next_s;
    logic [CW-1:0]     scan_cnt_r;
    logic [CW-1:0]     scan_cnt_next_s;
    logic [1:0]        scan_idx_r;
    logic [1:0]        scan_idx_next_s;

    logic [3:0]        digit_sel_next_s;
    logic [7:0]        segments_next_s;
    logic [3:0]        digit_sel_n_r;
    logic [7:0]        segments_r;

    // Two-flop synchronizer for the asynchronous MCU strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_s1_r <= 1'b0;
            strobe_s2_r <= 1'b0;
        end else begin
            strobe_s1_r <= wr_strobe;
            strobe_s2_r <= strobe_s1_r;
        end
    end

    // Handshake state register; wr_ack is high exactly while in HOLD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hs_state_r <= HS_IDLE;
            wr_ack_r   <= 1'b0;
        end else begin
            hs_state_r <= hs_next_s;
            wr_ack_r   <= (hs_next_s == HS_HOLD);
        end
    end

    // Handshake next state: one write on the rising strobe, then wait for
    // the strobe to drop so a held strobe cannot write twice.
    always_comb begin
        hs_next_s = hs_state_r;
        mem_we_s  = 1'b0;
        case (hs_state_r)
            HS_IDLE: begin
                if (strobe_s2_r) begin
                    mem_we_s  = 1'b1;
                    hs_next_s = HS_HOLD;
                end else begin
                    hs_next_s = HS_IDLE;
                end
            end
            HS_HOLD: begin
                if (!strobe_s2_r) begin
                    hs_next_s = HS_IDLE;
                end else begin
                    hs_next_s = HS_HOLD;
                end
            end
            default: begin
                hs_next_s = HS_IDLE;
            end
        endcase
    end

    // Digit register file. wr_addr/wr_data are stable for the whole strobe,
    // so they are safe to sample once the synchronized strobe is seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                digit_mem_r[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            digit_mem_r[wr_addr] <= wr_data;
        end
    end

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_state_r <= SC_SHOW;
            scan_cnt_r   <= '0;
            scan_idx_r   <= 2'd0;
        end else begin
            scan_state_r <= scan_next_s;
            scan_cnt_r   <= scan_cnt_next_s;
            scan_idx_r   <= scan_idx_next_s;
        end
    end

    // Scan next state: SHOW for SCAN_DIV-BLANK_CYCLES cycles, then BLANK for
    // BLANK_CYCLES cycles, advancing the digit index at the end of BLANK.
    always_comb begin
        scan_next_s     = scan_state_r;
        scan_cnt_next_s = scan_cnt_r + CW'(1);
        scan_idx_next_s = scan_idx_r;
        case (scan_state_r)
            SC_SHOW: begin
                if (scan_cnt_r == SHOW_LAST) begin
                    scan_cnt_next_s = '0;
                    scan_next_s     = SC_BLANK;
                end else begin
                    scan_next_s     = SC_SHOW;
                end
            end
            SC_BLANK: begin
                if (scan_cnt_r == BLANK_LAST) begin
                    scan_cnt_next_s = '0;
                    scan_idx_next_s = scan_idx_r + 2'd1;
                    scan_next_s     = SC_SHOW;
                end else begin
                    scan_next_s     = SC_BLANK;
                end
            end
            default: begin
                scan_cnt_next_s = '0;
                scan_idx_next_s = 2'd0;
                scan_next_s     = SC_SHOW;
            end
        endcase
    end

    // Output decode from the current scan position. Reading the register file
    // live means a write to the shown digit appears one clock after it lands,
    // with no disturbance to the selects.
    always_comb begin
        digit_sel_next_s = 4'b1111;
        segments_next_s  = 8'h00;
        if (enable && (scan_state_r == SC_SHOW)) begin
            digit_sel_next_s = digit_select(scan_idx_r);
            segments_next_s  = digit_mem_r[scan_idx_r];
        end else begin
            digit_sel_next_s = 4'b1111;
            segments_next_s  = 8'h00;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_sel_n_r <= 4'b1111;
            segments_r    <= 8'h00;
        end else begin
            digit_sel_n_r <= digit_sel_next_s;
            segments_r    <= segments_next_s;
        end
    end

    assign wr_ack      = wr_ack_r;
    assign digit_sel_n = digit_sel_n_r;
    assign segments    = segments_r;

    seg7_scan_checker u_checker (
        .clock       (clock),
        .reset_n     (reset_n),
        .digit_sel_n (digit_sel_n_r),
        .segments    (segments_r)
    );

endmodule

// -----------------------------------------------------------------------------
// seg7_scan_checker
//
// Output invariants of the scan controller.
//   clock, reset_n  clock and reset of the observed block
//   digit_sel_n     registered digit selects
//   segments        registered segment lines
// -----------------------------------------------------------------------------
module seg7_scan_checker (
    input logic       clock,
    input logic       reset_n,
    input logic [3:0] digit_sel_n,
    input logic [7:0] segments
);

    // Never two digits selected at once.
    a_one_cold: assert property (@(posedge clock) disable iff (!reset_n)
        $countones(~digit_sel_n) <= 1);

    // Segments are dark whenever no digit is selected.
    a_dark_when_blank: assert property (@(posedge clock) disable iff (!reset_n)
        (digit_sel_n == 4'b1111) |-> (segments == 8'h00));

endmodule

// File: tb/tb_seg7_scan_controller.sv
module tb_seg7_scan_controller;

    logic       clock;
    logic       reset_n;
    logic       wr_strobe;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       enable;
    logic       wr_ack;
    logic [3:0] digit_sel_n;
    logic [7:0] segments;

    seg7_scan_controller #(
        .SCAN_DIV     (16),
        .BLANK_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .enable      (enable),
        .wr_ack      (wr_ack),
        .digit_sel_n (digit_sel_n),
        .segments    (segments)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp_seg;
    } wr_vec_t;

    int         total;
    int         bad;
    int         edge_cnt;   // active edges since reset release
    logic       en_q;       // enable as sampled on the last active edge
    logic       seg_chk;
    logic [7:0] model_mem [4];
    wr_vec_t    vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int pos();
        return (edge_cnt - 1) % 64;
    endfunction

    function automatic logic shown();
        return (edge_cnt != 0) && en_q && ((pos() % 16) < 12);
    endfunction

    function automatic logic [3:0] exp_sel();
        logic [3:0] one;
        one = 4'b0001;
        if (!shown()) return 4'b1111;
        return ~(one << (pos() / 16));
    endfunction

    function automatic logic [7:0] exp_seg();
        if (!shown()) return 8'h00;
        return model_mem[pos() / 16];
    endfunction

    // Advance one clock and check the display against the free-running schedule.
    task automatic step();
        @(posedge clock);
        if (reset_n) begin
            edge_cnt = edge_cnt + 1;
            en_q     = enable;
        end
        @(negedge clock);
        chk("sel", 32'(digit_sel_n), 32'(exp_sel()));
        if (seg_chk) chk("seg", 32'(segments), 32'(exp_seg()));
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        seg_chk   = 1'b0;
        wr_addr   = a;
        wr_data   = d;
        wr_strobe = 1'b1;
        step(); chk("ack_rise_e1", 32'(wr_ack), 32'd0);
        step(); chk("ack_rise_e2", 32'(wr_ack), 32'd0);
        step(); chk("ack_rise_e3", 32'(wr_ack), 32'd1);
        model_mem[a] = d;
        wr_strobe = 1'b0;
        step(); chk("ack_fall_e1", 32'(wr_ack), 32'd1);
        seg_chk = 1'b1;
        step(); chk("ack_fall_e2", 32'(wr_ack), 32'd1);
        step(); chk("ack_fall_e3", 32'(wr_ack), 32'd0);
    endtask

    task automatic show_wait(input logic [1:0] a);
        logic [3:0] one;
        logic [3:0] tgt;
        int n;
        one = 4'b0001;
        tgt = ~(one << a);
        n = 0;
        while ((exp_sel() != tgt) && (n < 100)) begin
            step();
            n++;
        end
        if (n >= 100) chk("show_wait_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int lows;
        int d;
        logic [7:0] old;

        total = 0; bad = 0; edge_cnt = 0; en_q = 1'b0; seg_chk = 1'b1;
        for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
        vecs[0] = '{addr: 2'd2, data: 8'hFC, exp_seg: 8'hFC};
        vecs[1] = '{addr: 2'd0, data: 8'h3F, exp_seg: 8'h3F};
        vecs[2] = '{addr: 2'd1, data: 8'h06, exp_seg: 8'h06};
        vecs[3] = '{addr: 2'd3, data: 8'h4F, exp_seg: 8'h4F};

        reset_n = 1'b0; wr_strobe = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; enable = 1'b1;
        repeat (3) step();
        chk("reset_ack", 32'(wr_ack), 32'd0);
        reset_n = 1'b1;

        // First frame: schedule 1110x12,1111x4,... with dark segments.
        repeat (64) step();

        // Table-driven writes, then read back through the display.
        for (int i = 0; i < 4; i++) begin
            do_write(vecs[i].addr, vecs[i].data);
            show_wait(vecs[i].addr);
            chk("table_seg", 32'(segments), 32'(vecs[i].exp_seg));
        end
        repeat (64) step();

        // Held strobe: one write, one ack pulse, data change ignored.
        seg_chk = 1'b0;
        wr_addr = 2'd2; wr_data = 8'hDA; wr_strobe = 1'b1;
        step(); chk("held_ack_e1", 32'(wr_ack), 32'd0);
        step(); chk("held_ack_e2", 32'(wr_ack), 32'd0);
        step(); chk("held_ack_e3", 32'(wr_ack), 32'd1);
        model_mem[2] = 8'hDA;
        step();
        seg_chk = 1'b1;
        wr_data = 8'h60;
        lows = 0;
        repeat (100) begin
            step();
            if (!wr_ack) lows++;
        end
        chk("held_ack_stays", 32'(lows), 32'd0);
        wr_strobe = 1'b0;
        step(); chk("held_fall_e1", 32'(wr_ack), 32'd1);
        step(); chk("held_fall_e2", 32'(wr_ack), 32'd1);
        step(); chk("held_fall_e3", 32'(wr_ack), 32'd0);
        show_wait(2'd2);
        chk("held_mem2", 32'(segments), 32'h0DA);

        // Write to the digit currently in SHOW.
        n = 0;
        while (!(shown() && (pos() % 16) == 0) && (n < 100)) begin
            step();
            n++;
        end
        if (n >= 100) chk("live_wait_timeout", 32'(n), 32'd0);
        d = pos() / 16;
        old = model_mem[d];
        seg_chk = 1'b0;
        wr_addr = 2'(d); wr_data = 8'h0A; wr_strobe = 1'b1;
        step(); step(); step();
        chk("live_ack", 32'(wr_ack), 32'd1);
        chk("live_seg_old", 32'(segments), 32'(old));
        step();
        chk("live_seg_new", 32'(segments), 32'h0A);
        model_mem[d] = 8'h0A;
        seg_chk = 1'b1;
        wr_strobe = 1'b0;
        repeat (3) step();
        chk("live_ack_fall", 32'(wr_ack), 32'd0);

        // Enable low for 40 cycles mid-slot.
        n = 0;
        while (!(shown() && (pos() % 16) == 5) && (n < 100)) begin
            step();
            n++;
        end
        if (n >= 100) chk("en_wait_timeout", 32'(n), 32'd0);
        enable = 1'b0;
        step();
        chk("en_off_sel", 32'(digit_sel_n), 32'hF);
        chk("en_off_seg", 32'(segments), 32'h0);
        repeat (39) step();
        enable = 1'b1;
        step();
        repeat (64) step();

        // Reset during HOLD with the strobe still high.
        seg_chk = 1'b0;
        wr_addr = 2'd1; wr_data = 8'h3C; wr_strobe = 1'b1;
        repeat (3) step();
        chk("rst_pre_ack", 32'(wr_ack), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_ack", 32'(wr_ack), 32'd0);
        chk("rst_sel", 32'(digit_sel_n), 32'hF);
        chk("rst_seg", 32'(segments), 32'h0);
        edge_cnt = 0; en_q = 1'b0;
        for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
        @(negedge clock);
        repeat (2) step();
        reset_n = 1'b1;
        step(); chk("rst_rw_e1", 32'(wr_ack), 32'd0);
        step(); chk("rst_rw_e2", 32'(wr_ack), 32'd0);
        step(); chk("rst_rw_e3", 32'(wr_ack), 32'd1);
        model_mem[1] = 8'h3C;
        step();
        seg_chk = 1'b1;
        wr_strobe = 1'b0;
        repeat (3) step();
        chk("rst_rw_fall", 32'(wr_ack), 32'd0);
        repeat (64) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
